// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data memory arbiter: FSM state encoding and a
// one-hot to index helper used when recording the last served core.
package mem_arb_pkg;

  localparam int STATE_W   = 2;
  localparam int MAX_CORES = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic logic [2:0] onehot2idx(input logic [MAX_CORES-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CORES; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Core-side request/response lanes and RAM-side port of the shared data
// memory. The arbiter takes the slave view; the cores + RAM take master.
interface data_mem_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int AW      = 8,
  parameter int DW      = 8
);
  logic [N_CORES-1:0]    req;
  logic [N_CORES-1:0]    we;
  logic [N_CORES*AW-1:0] addr;
  logic [N_CORES*DW-1:0] wdata;
  logic [N_CORES-1:0]    lock;
  logic [N_CORES-1:0]    gnt;
  logic [N_CORES-1:0]    ack;
  logic [DW-1:0]         rdata;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_dout;
  logic                  mem_we;
  logic [DW-1:0]         mem_din;

  modport slave (
    input  req, we, addr, wdata, lock, mem_din,
    output gnt, ack, rdata, mem_addr, mem_dout, mem_we
  );

  modport master (
    output req, we, addr, wdata, lock, mem_din,
    input  gnt, ack, rdata, mem_addr, mem_dout, mem_we
  );
endinterface

// File: rtl/data_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible core searching upward
// from rr_last+1 with wraparound.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int IW      = $clog2(N_CORES)
) (
  input  logic [N_CORES-1:0] eligible,
  input  logic [IW-1:0]      rr_last,
  output logic [IW-1:0]      winner,
  output logic               any_valid
);

  // Scan offsets 1..N so the last served core is considered last.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= N_CORES; k++) begin
      idx = (int'(rr_last) + k) % N_CORES;
      if (!any_valid && eligible[idx]) begin
        winner    = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between N cores.
// One access at a time: IDLE (grant) -> ACCESS (MEM_LAT cycles) -> CAPTURE.
// Optional bus lock for read-modify-write: define MEM_ARB_LOCK_EN.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input logic              CLK,
  input logic              RST,
  data_mem_arbiter_if.slave bus
);

  localparam int IW = $clog2(N_CORES);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t               state;
  logic [N_CORES-1:0]   gnt_q;
  logic [N_CORES-1:0]   ack_q;
  logic [DW-1:0]        rdata_q;
  logic [AW-1:0]        mem_addr_q;
  logic [DW-1:0]        mem_dout_q;
  logic                 mem_we_q;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        rr_last;

  logic [N_CORES-1:0]   eligible;
  logic [IW-1:0]        win;
  logic                 any_valid;

`ifdef MEM_ARB_LOCK_EN
  logic                 lock_vld;
  logic [IW-1:0]        lock_idx;

  // While locked only the owner may win, and its own ack does not mask it
  // so a read can be followed immediately by the dependent write.
  always_comb begin
    eligible = bus.req & ~ack_q;
    if (lock_vld) begin
      eligible           = '0;
      eligible[lock_idx] = bus.req[lock_idx];
    end
  end

  // Lock ownership: taken at grant with lock=1, dropped on an unlocked
  // grant or when the owner stops requesting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else if (state == IDLE) begin
      if (lock_vld && !bus.req[lock_idx]) begin
        lock_vld <= 1'b0;
      end else if (any_valid) begin
        if (bus.lock[win]) begin
          lock_vld <= 1'b1;
          lock_idx <= win;
        end else begin
          lock_vld <= 1'b0;
        end
      end
    end
  end
`else
  // A core being acked this cycle is masked so it cannot win twice in a row.
  assign eligible = bus.req & ~ack_q;

  logic unused_lock;
  assign unused_lock = ^bus.lock;
`endif

  rr_pick #(.N_CORES(N_CORES), .IW(IW)) u_pick (
    .eligible  (eligible),
    .rr_last   (rr_last),
    .winner    (win),
    .any_valid (any_valid)
  );

  // Access FSM; all bus-facing outputs are registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      mem_we_q   <= 1'b0;
      cnt        <= '0;
      rr_last    <= IW'(N_CORES - 1);
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            // Request lanes are latched here; later changes are ignored.
            gnt_q      <= N_CORES'(1) << win;
            mem_addr_q <= bus.addr[int'(win)*AW +: AW];
            mem_dout_q <= bus.wdata[int'(win)*DW +: DW];
            mem_we_q   <= bus.we[win];
            cnt        <= CW'(MEM_LAT - 1);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
          if (cnt == '0) state <= CAPTURE;
          else           cnt   <= cnt - 1'b1;
        end
        CAPTURE: begin
          rdata_q <= bus.mem_din;
          ack_q   <= gnt_q;
          gnt_q   <= '0;
          rr_last <= IW'(onehot2idx(MAX_CORES'(gnt_q)));
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_we   = mem_we_q;

endmodule
